// File: rtl/cmd_src_arbiter_if.sv
// Bundle of the two requester ports and the cmd_proc port shared by cmd_src_arbiter.
// The master side is the arbiter; the slave side is its surroundings.
interface cmd_src_arbiter_if;
    logic [15:0] uart_cmd;
    logic        uart_rdy;
    logic        uart_clr;
    logic        uart_resp;
    logic [15:0] tour_cmd;
    logic        tour_rdy;
    logic        tour_clr;
    logic        tour_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic        owner;
    logic        busy;
    logic        tmo_err;

    modport master (
        input  uart_cmd, uart_rdy, tour_cmd, tour_rdy, clr_cmd_rdy, send_resp,
        output uart_clr, uart_resp, tour_clr, tour_resp, cmd, cmd_rdy, owner, busy, tmo_err
    );

    modport slave (
        output uart_cmd, uart_rdy, tour_cmd, tour_rdy, clr_cmd_rdy, send_resp,
        input  uart_clr, uart_resp, tour_clr, tour_resp, cmd, cmd_rdy, owner, busy, tmo_err
    );
endinterface

// File: rtl/cmd_src_arbiter.sv
// Shares the cmd_proc command port between UART_wrapper and TourCmd, holding each grant
// until send_resp, with a watchdog abort and a UART burst limit.
module cmd_src_arbiter #(
    parameter int TMO_CYC    = 50_000_000,
    parameter int UART_BURST = 3
) (
    input logic               clk,
    input logic               rst_n,
    cmd_src_arbiter_if.master bus
);

    localparam int WDOG_W  = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam int BURST_W = (UART_BURST > 0) ? $clog2(UART_BURST + 1) : 1;
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TMO_CYC - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(UART_BURST);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t             state, state_nx;
    logic [15:0]        cmd_q, cmd_nx;
    logic               cmd_rdy_q, cmd_rdy_nx;
    logic               owner_q, owner_nx;
    logic               busy_q, busy_nx;
    logic               uart_clr_q, uart_clr_nx;
    logic               uart_resp_q, uart_resp_nx;
    logic               tour_clr_q, tour_clr_nx;
    logic               tour_resp_q, tour_resp_nx;
    logic               tmo_q, tmo_nx;
    logic [BURST_W-1:0] burst_q, burst_nx;
    logic [WDOG_W-1:0]  wdog_q, wdog_nx;
    logic               take_uart, take_tour, wdog_done;

    // Tour wins a tie only once UART has used up its burst allowance.
    assign take_uart = bus.uart_rdy && (!bus.tour_rdy || burst_q != BURST_MAX);
    assign take_tour = bus.tour_rdy && !take_uart;
    assign wdog_done = (wdog_q == WDOG_LAST);

    always_comb begin
        state_nx     = state;
        cmd_nx       = cmd_q;
        cmd_rdy_nx   = cmd_rdy_q;
        owner_nx     = owner_q;
        busy_nx      = busy_q;
        burst_nx     = burst_q;
        wdog_nx      = wdog_q;
        uart_clr_nx  = 1'b0;
        uart_resp_nx = 1'b0;
        tour_clr_nx  = 1'b0;
        tour_resp_nx = 1'b0;
        tmo_nx       = 1'b0;

        case (state)
            IDLE: begin
                if (take_uart) begin
                    cmd_nx     = bus.uart_cmd;
                    cmd_rdy_nx = 1'b1;
                    owner_nx   = 1'b0;
                    busy_nx    = 1'b1;
                    wdog_nx    = '0;
                    state_nx   = ISSUE;
                    if (!bus.tour_rdy)
                        burst_nx = '0;
                    else if (burst_q != BURST_MAX)
                        burst_nx = burst_q + BURST_W'(1);
                end else if (take_tour) begin
                    cmd_nx     = bus.tour_cmd;
                    cmd_rdy_nx = 1'b1;
                    owner_nx   = 1'b1;
                    busy_nx    = 1'b1;
                    wdog_nx    = '0;
                    burst_nx   = '0;
                    state_nx   = ISSUE;
                end
            end

            ISSUE: begin
                if (bus.clr_cmd_rdy && bus.send_resp) begin
                    uart_clr_nx  = !owner_q;
                    tour_clr_nx  = owner_q;
                    uart_resp_nx = !owner_q;
                    tour_resp_nx = owner_q;
                    cmd_rdy_nx   = 1'b0;
                    busy_nx      = 1'b0;
                    state_nx     = IDLE;
                end else if (wdog_done) begin
                    tmo_nx     = 1'b1;
                    cmd_rdy_nx = 1'b0;
                    busy_nx    = 1'b0;
                    state_nx   = IDLE;
                end else begin
                    wdog_nx = wdog_q + WDOG_W'(1);
                    if (bus.clr_cmd_rdy) begin
                        uart_clr_nx = !owner_q;
                        tour_clr_nx = owner_q;
                        cmd_rdy_nx  = 1'b0;
                        state_nx    = BUSY;
                    end
                end
            end

            BUSY: begin
                if (bus.send_resp) begin
                    uart_resp_nx = !owner_q;
                    tour_resp_nx = owner_q;
                    busy_nx      = 1'b0;
                    state_nx     = IDLE;
                end else if (wdog_done) begin
                    tmo_nx     = 1'b1;
                    cmd_rdy_nx = 1'b0;
                    busy_nx    = 1'b0;
                    state_nx   = IDLE;
                end else begin
                    wdog_nx = wdog_q + WDOG_W'(1);
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_q       <= 16'h0000;
            cmd_rdy_q   <= 1'b0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            burst_q     <= '0;
            wdog_q      <= '0;
            uart_clr_q  <= 1'b0;
            uart_resp_q <= 1'b0;
            tour_clr_q  <= 1'b0;
            tour_resp_q <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            cmd_q       <= cmd_nx;
            cmd_rdy_q   <= cmd_rdy_nx;
            owner_q     <= owner_nx;
            busy_q      <= busy_nx;
            burst_q     <= burst_nx;
            wdog_q      <= wdog_nx;
            uart_clr_q  <= uart_clr_nx;
            uart_resp_q <= uart_resp_nx;
            tour_clr_q  <= tour_clr_nx;
            tour_resp_q <= tour_resp_nx;
            tmo_q       <= tmo_nx;
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.cmd_rdy   = cmd_rdy_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = busy_q;
    assign bus.uart_clr  = uart_clr_q;
    assign bus.uart_resp = uart_resp_q;
    assign bus.tour_clr  = tour_clr_q;
    assign bus.tour_resp = tour_resp_q;
    assign bus.tmo_err   = tmo_q;

endmodule

// File: tb/tb_cmd_src_arbiter.sv
// Directed bench for cmd_src_arbiter: a vector table for single-cycle behaviour,
// then hand-written burst-fairness and watchdog sequences.
module tb_cmd_src_arbiter;

    localparam int TMO_CYC    = 16;
    localparam int UART_BURST = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    cmd_src_arbiter_if bus ();

    cmd_src_arbiter #(
        .TMO_CYC    (TMO_CYC),
        .UART_BURST (UART_BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // flags = {cmd_rdy, owner, busy, uart_clr, uart_resp, tour_clr, tour_resp, tmo_err}
    typedef struct {
        string       name;
        logic        rst_n;
        logic        uart_rdy;
        logic [15:0] uart_cmd;
        logic        tour_rdy;
        logic [15:0] tour_cmd;
        logic        clr;
        logic        send;
        logic [15:0] exp_cmd;
        logic [7:0]  exp_flags;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(string name, logic rn, logic ur, logic tr, logic clr,
                                 logic send, logic [15:0] ecmd, logic [7:0] eflags);
        vec_t v;
        v.name      = name;
        v.rst_n     = rn;
        v.uart_rdy  = ur;
        v.uart_cmd  = 16'h4002;
        v.tour_rdy  = tr;
        v.tour_cmd  = 16'h5BF1;
        v.clr       = clr;
        v.send      = send;
        v.exp_cmd   = ecmd;
        v.exp_flags = eflags;
        return v;
    endfunction

    function automatic logic [23:0] outs();
        return {bus.cmd, bus.cmd_rdy, bus.owner, bus.busy, bus.uart_clr, bus.uart_resp,
                bus.tour_clr, bus.tour_resp, bus.tmo_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst_n           = v.rst_n;
        bus.uart_rdy    = v.uart_rdy;
        bus.uart_cmd    = v.uart_cmd;
        bus.tour_rdy    = v.tour_rdy;
        bus.tour_cmd    = v.tour_cmd;
        bus.clr_cmd_rdy = v.clr;
        bus.send_resp   = v.send;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] burst_seq[5];
        logic        burst_own[5];
        int          n;

        rst_n           = 1'b0;
        bus.uart_rdy    = 1'b0;
        bus.uart_cmd    = 16'h0000;
        bus.tour_rdy    = 1'b0;
        bus.tour_cmd    = 16'h0000;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;

        //                name         rn ur tr clr snd  cmd       flags
        vecs.push_back(mkv("reset",     0, 0, 0, 0, 0, 16'h0000, 8'b0000_0000));
        vecs.push_back(mkv("idle",      1, 0, 0, 0, 0, 16'h0000, 8'b0000_0000));
        vecs.push_back(mkv("u_grant",   1, 1, 0, 0, 0, 16'h4002, 8'b1010_0000));
        vecs.push_back(mkv("u_hold",    1, 1, 0, 0, 0, 16'h4002, 8'b1010_0000));
        vecs.push_back(mkv("u_clr",     1, 1, 0, 1, 0, 16'h4002, 8'b0011_0000));
        vecs.push_back(mkv("u_busy",    1, 0, 0, 0, 0, 16'h4002, 8'b0010_0000));
        vecs.push_back(mkv("u_resp",    1, 0, 0, 0, 1, 16'h4002, 8'b0000_1000));
        vecs.push_back(mkv("u_idle",    1, 0, 0, 0, 0, 16'h4002, 8'b0000_0000));
        vecs.push_back(mkv("t_grant",   1, 0, 1, 0, 0, 16'h5BF1, 8'b1110_0000));
        vecs.push_back(mkv("t_clr",     1, 0, 1, 1, 0, 16'h5BF1, 8'b0110_0100));
        vecs.push_back(mkv("t_resp",    1, 0, 0, 0, 1, 16'h5BF1, 8'b0100_0010));
        vecs.push_back(mkv("t_idle",    1, 0, 0, 0, 0, 16'h5BF1, 8'b0100_0000));
        vecs.push_back(mkv("c_grant",   1, 1, 0, 0, 0, 16'h4002, 8'b1010_0000));
        vecs.push_back(mkv("c_both",    1, 1, 0, 1, 1, 16'h4002, 8'b0001_1000));
        vecs.push_back(mkv("c_stray",   1, 0, 0, 0, 1, 16'h4002, 8'b0000_0000));
        vecs.push_back(mkv("r_grant",   1, 1, 0, 0, 0, 16'h4002, 8'b1010_0000));
        vecs.push_back(mkv("r_clr",     1, 1, 0, 1, 0, 16'h4002, 8'b0011_0000));
        vecs.push_back(mkv("r_reset",   0, 1, 0, 0, 0, 16'h0000, 8'b0000_0000));
        vecs.push_back(mkv("r_regrant", 1, 1, 0, 0, 0, 16'h4002, 8'b1010_0000));
        vecs.push_back(mkv("r_done",    1, 1, 0, 1, 1, 16'h4002, 8'b0001_1000));
        vecs.push_back(mkv("r_idle",    1, 0, 0, 0, 0, 16'h4002, 8'b0000_0000));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            step();
            check_output(vecs[i].name, {8'h00, outs()}, {8'h00, vecs[i].exp_cmd, vecs[i].exp_flags});
        end

        // Both sources held: three UART grants, then tour, then UART again.
        burst_seq[0] = 16'h4002; burst_own[0] = 1'b0;
        burst_seq[1] = 16'h4002; burst_own[1] = 1'b0;
        burst_seq[2] = 16'h4002; burst_own[2] = 1'b0;
        burst_seq[3] = 16'h5BF1; burst_own[3] = 1'b1;
        burst_seq[4] = 16'h4002; burst_own[4] = 1'b0;
        bus.uart_cmd = 16'h4002;
        bus.tour_cmd = 16'h5BF1;
        bus.uart_rdy = 1'b1;
        bus.tour_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_output($sformatf("burst_grant%0d", i), {14'h0, bus.cmd, bus.cmd_rdy, bus.owner},
                         {14'h0, burst_seq[i], 1'b1, burst_own[i]});
            bus.clr_cmd_rdy = 1'b1;
            step();
            bus.clr_cmd_rdy = 1'b0;
            check_output($sformatf("burst_clr%0d", i), {30'h0, bus.uart_clr, bus.tour_clr},
                         {30'h0, !burst_own[i], burst_own[i]});
            bus.send_resp = 1'b1;
            step();
            bus.send_resp = 1'b0;
            check_output($sformatf("burst_resp%0d", i), {29'h0, bus.busy, bus.uart_resp, bus.tour_resp},
                         {29'h0, 1'b0, !burst_own[i], burst_own[i]});
        end
        bus.uart_rdy = 1'b0;
        bus.tour_rdy = 1'b0;
        step();

        // Watchdog: UART command never completes while tour waits.
        bus.uart_rdy = 1'b1;
        step();
        check_output("wd_grant", {15'h0, bus.cmd, bus.cmd_rdy}, {15'h0, 16'h4002, 1'b1});
        bus.clr_cmd_rdy = 1'b1;
        bus.tour_rdy    = 1'b1;
        step();
        bus.clr_cmd_rdy = 1'b0;
        bus.uart_rdy    = 1'b0;
        n = 1;
        while (bus.tmo_err !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check_output("wd_latency", n, TMO_CYC);
        check_output("wd_abort", {28'h0, bus.busy, bus.cmd_rdy, bus.uart_resp, bus.tour_resp}, 32'h0);
        step();
        check_output("wd_tour_grant",
                     {12'h0, bus.cmd, bus.cmd_rdy, bus.owner, bus.busy, bus.tmo_err},
                     {12'h0, 16'h5BF1, 1'b1, 1'b1, 1'b1, 1'b0});
        bus.clr_cmd_rdy = 1'b1;
        bus.send_resp   = 1'b1;
        step();
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.tour_rdy    = 1'b0;
        check_output("wd_tour_done", {27'h0, bus.busy, bus.uart_clr, bus.uart_resp, bus.tour_clr, bus.tour_resp},
                     {27'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
